lru_age_n: RTL and testbench

Parametrised N-way least-recently-used tracker for one cache set, built on per-way saturating age counters with per-way valid bits and a per-way lock mask. The cache controller reports read hits (touch), line fills and invalidations. The tracker returns a registered victim way for the next fill, choosing invalid ways first, then the oldest unlocked way. It generalises the 4-entry LRU list to any power-of-two associativity and adds validity and pinning.

---
 rtl/lru_pkg.sv | 23 ++
 rtl/lru_victim_sel.sv | 86 ++++++++
 rtl/lru_age_n.sv | 160 ++++++++++++++++
 tb/tb_lru_age_n.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// lru_pkg
//   Shared definitions for the N-way LRU age tracker.
//   - lru_op_e  : the single operation applied to the set in a cycle,
//                 produced by the priority encoder in lru_age_n.
//   - lru_idx_w : way-index width rule, IDX_W = $clog2(WAYS).
package lru_pkg;

  // Largest associativity the tracker is written for.
  localparam int LRU_MAX_WAYS = 32;

  typedef enum logic [1:0] {
    LRU_OP_NONE  = 2'd0,
    LRU_OP_FILL  = 2'd1,
    LRU_OP_TOUCH = 2'd2,
    LRU_OP_INVAL = 2'd3
  } lru_op_e;

  // Way-index width for a given associativity.
  function automatic int lru_idx_w(input int ways);
    return $clog2(ways);
  endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// lru_victim_sel
//   Purely combinational replacement-way selector.
//   Picks the lowest-index way that is unlocked and invalid; if there is
//   none, the unlocked valid way with the largest age (lowest index on a
//   tie). A log2(WAYS)-level binary compare tree does the selection; each
//   node keeps its lower-index child unless the upper child is strictly
//   better, which makes ties resolve to the lower index.
//
//   Ports
//     valid_i  [WAYS]        per-way valid bits
//     age_i    [WAYS*AGE_W]  per-way ages, way w at bits w*AGE_W +: AGE_W
//     lock_i   [WAYS]        1 = way pinned, never a candidate
//     victim_o [IDX_W]       selected way, 0 when nothing is selectable
//     found_o                1 = at least one unlocked way exists
module lru_victim_sel
  import lru_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int AGE_W = 4,
  localparam int IDX_W = lru_idx_w(WAYS)
) (
  input  logic [WAYS-1:0]       valid_i,
  input  logic [WAYS*AGE_W-1:0] age_i,
  input  logic [WAYS-1:0]       lock_i,
  output logic [IDX_W-1:0]      victim_o,
  output logic                  found_o
);

  localparam int LEVELS = IDX_W;

  // Level 0 holds one node per way; level LEVELS holds the single root.
  // A node carries: cand (unlocked), inval (way is invalid), its age and
  // the way index it represents.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = WAYS >> l;

    logic [N-1:0]       cand;
    logic [N-1:0]       inval;
    logic [AGE_W-1:0]   age [N];
    logic [IDX_W-1:0]   idx [N];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_way
        assign cand[i]  = ~lock_i[i];
        assign inval[i] = ~valid_i[i];
        assign age[i]   = age_i[i*AGE_W +: AGE_W];
        assign idx[i]   = IDX_W'(i);
      end
    end else begin : g_node
      for (genvar i = 0; i < N; i++) begin : g_pair
        logic lo_cand, hi_cand;
        logic lo_inval, hi_inval;
        logic [AGE_W-1:0] lo_age, hi_age;
        logic take_hi;

        assign lo_cand  = g_lvl[l-1].cand[2*i];
        assign hi_cand  = g_lvl[l-1].cand[2*i+1];
        assign lo_inval = g_lvl[l-1].inval[2*i];
        assign hi_inval = g_lvl[l-1].inval[2*i+1];
        assign lo_age   = g_lvl[l-1].age[2*i];
        assign hi_age   = g_lvl[l-1].age[2*i+1];

        // The upper child wins only when strictly preferable: it is a
        // candidate and the lower is not, or it is invalid while the lower
        // is valid, or both are valid and it is strictly older.
        assign take_hi = hi_cand &&
                         (!lo_cand ||
                          (hi_inval && !lo_inval) ||
                          (!hi_inval && !lo_inval && (hi_age > lo_age)));

        assign cand[i]  = take_hi ? hi_cand  : lo_cand;
        assign inval[i] = take_hi ? hi_inval : lo_inval;
        assign age[i]   = take_hi ? hi_age   : lo_age;
        assign idx[i]   = take_hi ? g_lvl[l-1].idx[2*i+1] : g_lvl[l-1].idx[2*i];
      end
    end
  end

  assign found_o  = g_lvl[LEVELS].cand[0];
  assign victim_o = found_o ? g_lvl[LEVELS].idx[0] : '0;

  // The root's inval flag and age only matter inside the tree.
  logic unused_root_bits;
  assign unused_root_bits = ^{g_lvl[LEVELS].inval, g_lvl[LEVELS].age[0]};

endmodule

// File: rtl/lru_age_n.sv
// lru_age_n
//   N-way least-recently-used tracker for one cache set. Each way keeps a
//   valid bit and a saturating age counter; the replacement candidate for
//   the next fill is computed from the next state and registered.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     touch_i/_way_i  read hit on a way (ignored if that way is invalid)
//     fill_i/_way_i   line written into a way
//     inval_i/_way_i  way invalidated
//     lock_mask_i     1 = way pinned, never chosen as victim
//     victim_o        registered replacement way
//     victim_valid_o  registered, 0 when every way is locked
//     all_valid_o     registered, every way valid
//
//   Only one request acts per cycle, priority fill > touch > inval; the
//   losers in a cycle are dropped.
module lru_age_n
  import lru_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int AGE_W = 4,
  localparam int IDX_W = lru_idx_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_i,
  input  logic [IDX_W-1:0] touch_way_i,
  input  logic             fill_i,
  input  logic [IDX_W-1:0] fill_way_i,
  input  logic             inval_i,
  input  logic [IDX_W-1:0] inval_way_i,
  input  logic [WAYS-1:0]  lock_mask_i,
  output logic [IDX_W-1:0] victim_o,
  output logic             victim_valid_o,
  output logic             all_valid_o
);

  // Saturating +1: a way at max age stays there, so ordering among
  // saturated ways is lost and the tree falls back to lowest index.
  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  lru_op_e op;

  logic [WAYS-1:0]    valid_q, valid_d;
  logic [AGE_W-1:0]   age_q [WAYS];
  logic [AGE_W-1:0]   age_d [WAYS];
  logic [WAYS*AGE_W-1:0] age_d_flat;

  logic [IDX_W-1:0]   victim_q, victim_d;
  logic               victim_valid_q, victim_valid_d;
  logic               all_valid_q, all_valid_d;

  logic               do_age;
  logic [IDX_W-1:0]   hit_way;

  // Priority encoder reducing the three request lines to one operation.
  always_comb begin
    op = LRU_OP_NONE;
    if (fill_i) begin
      op = LRU_OP_FILL;
    end else if (touch_i) begin
      op = LRU_OP_TOUCH;
    end else if (inval_i) begin
      op = LRU_OP_INVAL;
    end
  end

  // Fill and a touch of a valid way share the same update: the hit way
  // becomes youngest and every other valid way ages by one. Invalid ways
  // are left alone so they stay at age 0.
  always_comb begin
    do_age  = 1'b0;
    hit_way = '0;
    case (op)
      LRU_OP_FILL: begin
        do_age  = 1'b1;
        hit_way = fill_way_i;
      end
      LRU_OP_TOUCH: begin
        do_age  = valid_q[touch_way_i];
        hit_way = touch_way_i;
      end
      default: begin
        do_age  = 1'b0;
        hit_way = '0;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    for (int j = 0; j < WAYS; j++) begin
      age_d[j] = age_q[j];
    end

    if (do_age) begin
      for (int j = 0; j < WAYS; j++) begin
        if (IDX_W'(j) == hit_way) begin
          valid_d[j] = 1'b1;
          age_d[j]   = '0;
        end else if (valid_q[j]) begin
          age_d[j]   = sat_inc(age_q[j]);
        end
      end
    end else if (op == LRU_OP_INVAL) begin
      valid_d[inval_way_i] = 1'b0;
      age_d[inval_way_i]   = '0;
    end
  end

  always_comb begin
    age_d_flat = '0;
    for (int j = 0; j < WAYS; j++) begin
      age_d_flat[j*AGE_W +: AGE_W] = age_d[j];
    end
  end

  // Selection runs on the next state so the registered outputs already
  // describe the set as it stands after this edge.
  lru_victim_sel #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_victim_sel (
    .valid_i  (valid_d),
    .age_i    (age_d_flat),
    .lock_i   (lock_mask_i),
    .victim_o (victim_d),
    .found_o  (victim_valid_d)
  );

  assign all_valid_d = &valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      for (int j = 0; j < WAYS; j++) begin
        age_q[j]     <= '0;
      end
      victim_q       <= '0;
      victim_valid_q <= 1'b0;
      all_valid_q    <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      for (int j = 0; j < WAYS; j++) begin
        age_q[j]     <= age_d[j];
      end
      victim_q       <= victim_d;
      victim_valid_q <= victim_valid_d;
      all_valid_q    <= all_valid_d;
    end
  end

  assign victim_o       = victim_q;
  assign victim_valid_o = victim_valid_q;
  assign all_valid_o    = all_valid_q;

endmodule

// File: tb/tb_lru_age_n.sv
// tb_lru_age_n
//   Self-checking bench for lru_age_n (4 ways, 2-bit ages so saturation
//   is reached quickly). A behavioural model tracks valid bits and integer
//   ages and picks the victim by scanning the ways; directed steps walk
//   the main scenarios, then a randomized phase exercises mixed traffic.
module tb_lru_age_n;

  localparam int WAYS  = 4;
  localparam int AGE_W = 2;
  localparam int IDX_W = 2;
  localparam int AMAX  = (1 << AGE_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             touch_i;
  logic [IDX_W-1:0] touch_way_i;
  logic             fill_i;
  logic [IDX_W-1:0] fill_way_i;
  logic             inval_i;
  logic [IDX_W-1:0] inval_way_i;
  logic [WAYS-1:0]  lock_mask_i;
  logic [IDX_W-1:0] victim_o;
  logic             victim_valid_o;
  logic             all_valid_o;

  lru_age_n #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .touch_i        (touch_i),
    .touch_way_i    (touch_way_i),
    .fill_i         (fill_i),
    .fill_way_i     (fill_way_i),
    .inval_i        (inval_i),
    .inval_way_i    (inval_way_i),
    .lock_mask_i    (lock_mask_i),
    .victim_o       (victim_o),
    .victim_valid_o (victim_valid_o),
    .all_valid_o    (all_valid_o)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  bit m_valid [WAYS];
  int m_age   [WAYS];
  int exp_victim;
  bit exp_vv;
  bit exp_av;

  // Victim per the selection rules: first unlocked invalid way, else the
  // oldest unlocked valid way with ties to the lowest index.
  task automatic modelSelect(input logic [WAYS-1:0] lock);
    int best;
    exp_victim = 0;
    exp_vv     = 1'b0;
    best       = -1;
    for (int j = 0; j < WAYS; j++) begin
      if (!m_valid[j] && !lock[j] && best < 0) best = j;
    end
    if (best < 0) begin
      for (int j = 0; j < WAYS; j++) begin
        if (m_valid[j] && !lock[j] && (best < 0 || m_age[j] > m_age[best])) best = j;
      end
    end
    if (best >= 0) begin
      exp_victim = best;
      exp_vv     = 1'b1;
    end
    exp_av = 1'b1;
    for (int j = 0; j < WAYS; j++) if (!m_valid[j]) exp_av = 1'b0;
  endtask

  task automatic modelReset();
    for (int j = 0; j < WAYS; j++) begin
      m_valid[j] = 1'b0;
      m_age[j]   = 0;
    end
    exp_victim = 0;
    exp_vv     = 1'b0;
    exp_av     = 1'b0;
  endtask

  task automatic modelAgeOthers(input int w);
    for (int j = 0; j < WAYS; j++) begin
      if (j != w && m_valid[j]) m_age[j] = (m_age[j] < AMAX) ? m_age[j] + 1 : AMAX;
    end
  endtask

  task automatic modelStep(input bit f, input int fw, input bit t, input int tw,
                           input bit iv, input int iw, input logic [WAYS-1:0] lock);
    if (f) begin
      modelAgeOthers(fw);
      m_valid[fw] = 1'b1;
      m_age[fw]   = 0;
    end else if (t) begin
      if (m_valid[tw]) begin
        modelAgeOthers(tw);
        m_age[tw] = 0;
      end
    end else if (iv) begin
      m_valid[iw] = 1'b0;
      m_age[iw]   = 0;
    end
    modelSelect(lock);
  endtask

  task automatic checkOutput(input string tag);
    compared++;
    assert (victim_o === IDX_W'(exp_victim)) else begin
      mismatched++;
      $error("[TB] FAIL %s victim_o observed=%0d expected=%0d", tag, victim_o, exp_victim);
    end
    compared++;
    assert (victim_valid_o === exp_vv) else begin
      mismatched++;
      $error("[TB] FAIL %s victim_valid_o observed=%0b expected=%0b", tag, victim_valid_o, exp_vv);
    end
    compared++;
    assert (all_valid_o === exp_av) else begin
      mismatched++;
      $error("[TB] FAIL %s all_valid_o observed=%0b expected=%0b", tag, all_valid_o, exp_av);
    end
  endtask

  // Hand-derived expectation for a directed checkpoint.
  task automatic checkConst(input string tag, input int observed, input int expected);
    compared++;
    assert (observed == expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests, step the model at the edge, sample 1ns
  // later, then release the request lines (the lock mask is held).
  task automatic applyStimulus(input bit f, input int fw, input bit t, input int tw,
                               input bit iv, input int iw, input logic [WAYS-1:0] lock,
                               input string tag);
    fill_i      = f;
    fill_way_i  = IDX_W'(fw);
    touch_i     = t;
    touch_way_i = IDX_W'(tw);
    inval_i     = iv;
    inval_way_i = IDX_W'(iw);
    lock_mask_i = lock;
    @(posedge clk);
    modelStep(f, fw, t, tw, iv, iw, lock);
    #1;
    fill_i  = 1'b0;
    touch_i = 1'b0;
    inval_i = 1'b0;
    checkOutput(tag);
  endtask

  // Reset with a fill pending: the fill must be discarded.
  task automatic doReset(input int fw);
    rst        = 1'b1;
    fill_i     = 1'b1;
    fill_way_i = IDX_W'(fw);
    @(posedge clk);
    modelReset();
    #1;
    rst    = 1'b0;
    fill_i = 1'b0;
    checkOutput("reset");
  endtask

  task automatic idle(input logic [WAYS-1:0] lock, input string tag);
    applyStimulus(0, 0, 0, 0, 0, 0, lock, tag);
  endtask

  task automatic fill(input int w, input string tag);
    applyStimulus(1, w, 0, 0, 0, 0, lock_mask_i, tag);
  endtask

  task automatic touch(input int w, input string tag);
    applyStimulus(0, 0, 1, w, 0, 0, lock_mask_i, tag);
  endtask

  task automatic inval(input int w, input string tag);
    applyStimulus(0, 0, 0, 0, 1, w, lock_mask_i, tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst         = 1'b1;
    touch_i     = 1'b0;
    touch_way_i = '0;
    fill_i      = 1'b0;
    fill_way_i  = '0;
    inval_i     = 1'b0;
    inval_way_i = '0;
    lock_mask_i = '0;
    modelReset();

    // Reset then idle
    doReset(2);
    idle(4'b0000, "idle_after_reset");
    checkConst("idle_victim", int'(victim_o), 0);
    checkConst("idle_vv", int'(victim_valid_o), 1);
    checkConst("idle_av", int'(all_valid_o), 0);

    // Fill 0..3 gives ages 3,2,1,0
    for (int w = 0; w < WAYS; w++) fill(w, "fill_seq");
    checkConst("fill_all_valid", int'(all_valid_o), 1);
    checkConst("fill_victim", int'(victim_o), 0);
    touch(0, "touch0");
    checkConst("touch0_victim", int'(victim_o), 1);
    touch(1, "touch1");
    checkConst("touch1_victim", int'(victim_o), 2);

    // Locking with ages 3,2,1,0
    doReset(0);
    for (int w = 0; w < WAYS; w++) fill(w, "fill_seq2");
    idle(4'b0001, "lock0001");
    checkConst("lock0001_victim", int'(victim_o), 1);
    idle(4'b1111, "lock1111");
    checkConst("lock1111_vv", int'(victim_valid_o), 0);
    checkConst("lock1111_victim", int'(victim_o), 0);

    // Simultaneous fill 3 / touch 1 / inval 0: only the fill acts
    idle(4'b0000, "unlock");
    applyStimulus(1, 3, 1, 1, 1, 0, 4'b0000, "simultaneous");
    checkConst("simul_all_valid", int'(all_valid_o), 1);
    checkConst("simul_victim", int'(victim_o), 0);

    // Touch of an invalid way changes nothing
    inval(2, "inval2");
    touch(2, "touch_invalid");
    idle(4'b0000, "after_touch_invalid");

    // Saturation with 2-bit ages
    doReset(1);
    fill(0, "sat_fill0");
    fill(1, "sat_fill1");
    for (int k = 0; k < 6; k++) touch(1, "sat_touch1");
    checkConst("sat_victim_invalid_first", int'(victim_o), 2);
    inval(2, "sat_inval2");
    inval(3, "sat_inval3");
    fill(2, "sat_fill2");
    fill(3, "sat_fill3");
    checkConst("sat_victim_oldest", int'(victim_o), 0);

    // Reset asserted during a fill
    for (int w = 0; w < WAYS; w++) fill(w, "fill_seq3");
    doReset(3);
    checkConst("reset_fill_av", int'(all_valid_o), 0);
    idle(4'b0000, "idle_after_reset2");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        doReset(int'($urandom_range(0, WAYS - 1)));
      end else begin
        logic [WAYS-1:0] lock;
        lock = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '0;
        applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, WAYS - 1)),
                      $urandom_range(0, 1) == 1, int'($urandom_range(0, WAYS - 1)),
                      $urandom_range(0, 4) == 0, int'($urandom_range(0, WAYS - 1)),
                      lock, "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
